// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller covering load-use stalls, branch flushes,
// memory-wait freezes with a 255-cycle timeout, and stall/flush event counters.
`timescale 1ns/1ps
`default_nettype none

module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_RS1addr_i,
  input  logic [4:0]  ID_RS2addr_i,
  input  logic        ID_UsesRS2_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_RDaddr_i,
  input  logic        BranchTaken_i,
  input  logic        MemReq_i,
  input  logic        MemAck_i,
  output logic        PCWrite_o,
  output logic        IFID_Stall_o,
  output logic        IFID_Flush_o,
  output logic        IDEX_NoOp_o,
  output logic        Freeze_o,
  output logic        Err_o,
  output logic [1:0]  State_o,
  output logic [15:0] StallCnt_o,
  output logic [15:0] FlushCnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b11
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'd254;

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;
  logic        load_use;
  logic        mem_entry;

  always_comb begin
    load_use  = EX_MemRead_i && (EX_RDaddr_i != 5'd0) &&
                ((EX_RDaddr_i == ID_RS1addr_i) ||
                 (ID_UsesRS2_i && (EX_RDaddr_i == ID_RS2addr_i)));
    mem_entry = (state_q == RUN) && MemReq_i && !MemAck_i;

    PCWrite_o    = 1'b1;
    IFID_Stall_o = 1'b0;
    IFID_Flush_o = 1'b0;
    IDEX_NoOp_o  = 1'b0;
    Freeze_o     = 1'b0;

    state_d = state_q;
    wait_d  = wait_q;
    pend_d  = pend_q;
    err_d   = err_q;

    case (state_q)
      ERROR: begin
        PCWrite_o    = 1'b0;
        IFID_Stall_o = 1'b1;
        Freeze_o     = 1'b1;
      end
      MEM_WAIT: begin
        PCWrite_o    = 1'b0;
        IFID_Stall_o = 1'b1;
        Freeze_o     = 1'b1;
        pend_d       = pend_q | BranchTaken_i;
        if (MemAck_i) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        if (mem_entry) begin
          PCWrite_o    = 1'b0;
          IFID_Stall_o = 1'b1;
          Freeze_o     = 1'b1;
          state_d      = MEM_WAIT;
          wait_d       = 8'd0;
          pend_d       = pend_q | BranchTaken_i;
        end else if (load_use) begin
          // Branch is not taken here; it re-resolves once the bubble clears.
          PCWrite_o    = 1'b0;
          IFID_Stall_o = 1'b1;
          IDEX_NoOp_o  = 1'b1;
        end else if (BranchTaken_i || pend_q) begin
          IFID_Flush_o = 1'b1;
          pend_d       = 1'b0;
        end
      end
    endcase

    // Mealy outputs must not react to inputs while reset is held.
    if (!rst_i) begin
      PCWrite_o    = 1'b1;
      IFID_Stall_o = 1'b0;
      IFID_Flush_o = 1'b0;
      IDEX_NoOp_o  = 1'b0;
      Freeze_o     = 1'b0;
    end

    stall_d = (!PCWrite_o && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
    flush_d = (IFID_Flush_o && (flush_q != 16'hFFFF)) ? flush_q + 16'd1 : flush_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign Err_o      = err_q;
  assign State_o    = state_q;
  assign StallCnt_o = stall_q;
  assign FlushCnt_o = flush_q;

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk_i  input  1  rising-edge clock.
REQ-002 SHALL have port rst_i  input  1  reset, asynchronous, active-low; clock clk_i.
REQ-003 SHALL have port ID_RS1addr_i  input  5  rs1 of the instruction in ID.
REQ-004 SHALL have port ID_RS2addr_i  input  5  rs2 of the instruction in ID.
REQ-005 SHALL have port ID_UsesRS2_i  input  1  ID instruction reads rs2.
REQ-006 SHALL have port EX_MemRead_i  input  1  instruction in EX is a load.
REQ-007 SHALL have port EX_RDaddr_i  input  5  rd of the instruction in EX.
REQ-008 SHALL have port BranchTaken_i  input  1  branch resolved taken in ID this cycle.
REQ-009 SHALL have port MemReq_i  input  1  MEM stage issues a data-memory access this cycle.
REQ-010 SHALL have port MemAck_i  input  1  data memory completes the access this cycle.
REQ-011 SHALL have port PCWrite_o  output  1  PC update enable.
REQ-012 SHALL have port IFID_Stall_o  output  1  hold the IF/ID register.
REQ-013 SHALL have port IFID_Flush_o  output  1  clear the IF/ID register.
REQ-014 SHALL have port IDEX_NoOp_o  output  1  zero the ID/EX control bits (bubble).
REQ-015 SHALL have port Freeze_o  output  1  hold all pipeline registers.
REQ-016 SHALL have port Err_o  output  1  sticky memory-timeout error.
REQ-017 SHALL have port State_o  output  2  current state encoding.
REQ-018 SHALL have port StallCnt_o  output  16  cycles with PCWrite_o=0.
REQ-019 SHALL have port FlushCnt_o  output  16  cycles with IFID_Flush_o=1.

Function
REQ-020 SHALL implement states RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b11; State_o shall equal the state register.
REQ-021 SHALL define load-use LU = EX_MemRead_i & (EX_RDaddr_i!=0) & ((EX_RDaddr_i==ID_RS1addr_i) | (ID_UsesRS2_i & EX_RDaddr_i==ID_RS2addr_i)).
REQ-022 SHALL transition RUN->MEM_WAIT when MemReq_i=1 and MemAck_i=0; MemReq_i=1 with MemAck_i=1 stays in RUN (zero-wait access).
REQ-023 SHALL transition MEM_WAIT->RUN on the first cycle MemAck_i=1.
REQ-024 SHALL keep an 8-bit wait counter, cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle without MemAck_i; reaching 255 without ack SHALL transition to ERROR and set Err_o.
REQ-025 SHALL keep ERROR and Err_o=1 until reset, ignoring all inputs.
REQ-026 SHALL drive outputs combinationally (Mealy) from state and inputs, with priority ERROR > MEM_WAIT-or-entry > LU > BranchTaken_i.
REQ-027 In ERROR: Freeze_o=1, PCWrite_o=0, IFID_Stall_o=1, IFID_Flush_o=0, IDEX_NoOp_o=0.
REQ-028 In MEM_WAIT (also the RUN entry cycle with MemReq_i=1 and MemAck_i=0): Freeze_o=1, PCWrite_o=0, IFID_Stall_o=1, IFID_Flush_o=0, IDEX_NoOp_o=0.
REQ-029 A BranchTaken_i seen while frozen SHALL be latched in a pending flag and the flush issued on the first RUN cycle after the freeze, then the flag cleared.
REQ-030 In RUN with LU=1: PCWrite_o=0, IFID_Stall_o=1, IDEX_NoOp_o=1, IFID_Flush_o=0; branch flush suppressed (branch re-evaluates next cycle), and pending flag unchanged.
REQ-031 In RUN with LU=0 and (BranchTaken_i or pending): IFID_Flush_o=1, PCWrite_o=1, others 0.
REQ-032 Otherwise: PCWrite_o=1, all other control outputs 0.
REQ-033 StallCnt_o and FlushCnt_o SHALL increment on clock edges per REQ-018/019 and saturate at 16'hFFFF.

Reset
REQ-034 While rst_i=0: state RUN, wait counter 0, pending 0, Err_o=0, StallCnt_o=0, FlushCnt_o=0, PCWrite_o=1, IFID_Stall_o=0, IFID_Flush_o=0, IDEX_NoOp_o=0, Freeze_o=0, regardless of inputs.
REQ-035 Reset asserted mid-MEM_WAIT or in ERROR SHALL return to RUN immediately (asynchronously), discarding the pending flush.

Verification
REQ-036 Load-use: EX_MemRead_i=1, EX_RDaddr_i=5, ID_RS1addr_i=5 for 1 cycle -> PCWrite_o=0, IFID_Stall_o=1, IDEX_NoOp_o=1; StallCnt_o=1; with EX_RDaddr_i=0 -> no stall.
REQ-037 rs2 qualification: EX_RDaddr_i=7, ID_RS2addr_i=7, ID_UsesRS2_i=0 -> no stall; ID_UsesRS2_i=1 -> stall.
REQ-038 Memory wait: MemReq_i=1, MemAck_i after 3 cycles -> Freeze_o=1 for 4 cycles (entry + 3 in MEM_WAIT, last with ack), State_o 01 then 00; StallCnt_o=4.
REQ-039 Branch during freeze: BranchTaken_i pulsed in MEM_WAIT -> IFID_Flush_o=1 exactly one cycle after return to RUN; FlushCnt_o=1.
REQ-040 Simultaneous LU and BranchTaken_i -> stall only, no flush that cycle.
REQ-041 Timeout: MemReq_i=1, MemAck_i held 0 -> after 255 MEM_WAIT cycles State_o=11, Err_o=1; persists until rst_i=0, after which all outputs match REQ-034.
